seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_pkg.sv | 63 ++++++
 rtl/seg_font.sv | 11 +
 rtl/seg_scan.sv | 57 +++++
 tb/tb_seg_scan.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared 7-segment character codes and glyph table.
// Glyphs are active-low {g,f,e,d,c,b,a}; codes without a glyph decode to a dash.
package seg_scan_pkg;

    typedef enum logic {BLANK, SHOW} slot_t;

    localparam logic [4:0] CH_A     = 5'd10;
    localparam logic [4:0] CH_B     = 5'd11;
    localparam logic [4:0] CH_C     = 5'd12;
    localparam logic [4:0] CH_D     = 5'd13;
    localparam logic [4:0] CH_E     = 5'd14;
    localparam logic [4:0] CH_F     = 5'd15;
    localparam logic [4:0] CH_G     = 5'd16;
    localparam logic [4:0] CH_H     = 5'd17;
    localparam logic [4:0] CH_J     = 5'd18;
    localparam logic [4:0] CH_L     = 5'd19;
    localparam logic [4:0] CH_N     = 5'd20;
    localparam logic [4:0] CH_O     = 5'd21;
    localparam logic [4:0] CH_P     = 5'd22;
    localparam logic [4:0] CH_R     = 5'd23;
    localparam logic [4:0] CH_T     = 5'd24;
    localparam logic [4:0] CH_U     = 5'd25;
    localparam logic [4:0] CH_Y     = 5'd26;
    localparam logic [4:0] CH_UNDER = 5'd27;
    localparam logic [4:0] CH_DASH  = 5'd28;
    localparam logic [4:0] CH_BLANK = 5'd31;

    function automatic logic [6:0] glyph(input logic [4:0] code);
        case (code)
            5'd0:     return 7'h40;
            5'd1:     return 7'h79;
            5'd2:     return 7'h24;
            5'd3:     return 7'h30;
            5'd4:     return 7'h19;
            5'd5:     return 7'h12;
            5'd6:     return 7'h02;
            5'd7:     return 7'h78;
            5'd8:     return 7'h00;
            5'd9:     return 7'h10;
            CH_A:     return 7'h08;
            CH_B:     return 7'h03;
            CH_C:     return 7'h46;
            CH_D:     return 7'h21;
            CH_E:     return 7'h06;
            CH_F:     return 7'h0E;
            CH_G:     return 7'h42;
            CH_H:     return 7'h09;
            CH_J:     return 7'h61;
            CH_L:     return 7'h47;
            CH_N:     return 7'h2B;
            CH_O:     return 7'h23;
            CH_P:     return 7'h0C;
            CH_R:     return 7'h2F;
            CH_T:     return 7'h07;
            CH_U:     return 7'h41;
            CH_Y:     return 7'h11;
            CH_UNDER: return 7'h77;
            CH_BLANK: return 7'h7F;
            default:  return 7'h3F;
        endcase
    endfunction

endpackage

// File: rtl/seg_font.sv
// seg_font: combinational 5-bit character code to active-low 7-segment pattern.
module seg_font
    import seg_scan_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pat
);

    always_comb pat = glyph(code);

endmodule

// File: rtl/seg_scan.sv
// seg_scan: 4-digit multiplexed 7-segment scanner with per-slot blanking
// and a per-frame snapshot of the character codes so a frame never tears.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 24000,
    parameter int BLANK_CYC = 2400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] data,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = $clog2(SCAN_DIV);

    if (SCAN_DIV < 2 || BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV) begin : g_bad_params
        $error("seg_scan: need SCAN_DIV>=2 and 1<=BLANK_CYC<SCAN_DIV");
    end

    logic [CW-1:0]   cnt;
    logic [1:0]      dig;
    logic [3:0][4:0] snap;
    slot_t           state;
    logic [6:0]      pat;
    logic            last;

    assign last = cnt == CW'(SCAN_DIV - 1);
    assign dp   = 1'b1;

    seg_font u_font (.code(snap[dig]), .pat(pat));

    // state tracks cnt>=BLANK_CYC one step ahead so the output stage needs no compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            dig        <= 2'd3;
            snap       <= {4{CH_BLANK}};
            state      <= BLANK;
            an         <= 4'hF;
            seg        <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            cnt        <= last ? '0 : cnt + 1'b1;
            dig        <= last ? dig - 1'b1 : dig;
            state      <= last ? BLANK : (cnt == CW'(BLANK_CYC - 1) ? SHOW : state);
            snap       <= (dig == 2'd3 && cnt == '0) ? data : snap;
            an         <= state == SHOW ? ~(4'b0001 << dig) : 4'hF;
            seg        <= state == SHOW ? pat : 7'h7F;
            frame_done <= last && dig == 2'd0;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized self-checking bench for seg_scan (SCAN_DIV=8, BLANK_CYC=2)
// against a frame/slot arithmetic reference model.
module tb_seg_scan;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] data = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int vectors = 0;
    int errs = 0;
    int n = 0;
    logic [3:0][4:0] snap_m;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;

    seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .data(data), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [4:0] c);
        logic [6:0] hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        if (c < 5'd16) return hex[c[3:0]];
        if (c == 5'd16) return 7'h42;
        if (c == 5'd17) return 7'h09;
        if (c == 5'd31) return 7'h7F;
        return 7'h3F;
    endfunction

    function automatic logic [4:0] rand_code();
        int r = $urandom_range(0, 19);
        return r == 18 ? 5'd29 : r == 19 ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [19:0] rand_data();
        return {rand_code(), rand_code(), rand_code(), rand_code()};
    endfunction

    // One clock: model counts edges since reset release; the frame snapshot is data at each frame's first edge.
    task automatic advance();
        int p, d, c;
        @(posedge clk);
        n++;
        if ((n - 1) % FRAME == 0) snap_m = data;
        p = (n - 1) % FRAME;
        d = 3 - p / SD;
        c = p % SD;
        exp_an  = c >= BC ? ~(4'b0001 << d) : 4'hF;
        exp_seg = c >= BC ? ref_glyph(snap_m[d]) : 7'h7F;
        exp_fd  = p == FRAME - 1;
        @(negedge clk);
    endtask

    task automatic restart(input logic [19:0] d);
        rst = 1'b1;
        data = d;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data = $urandom();
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
                errs++;
                $display("FAIL reset: an=%b seg=%h dp=%b fd=%b, want 1111 7f 1 0", an, seg, dp, frame_done);
            end
        end
    endtask

    task automatic test_zero_frame();
        restart(20'h0);
        repeat (2 * FRAME + 4) begin
            advance();
            vectors++;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd || dp !== 1'b1) begin
                errs++;
                $display("FAIL zero_frame n=%0d: an=%b/%b seg=%h/%h fd=%b/%b dp=%b (got/want)",
                         n, an, exp_an, seg, exp_seg, frame_done, exp_fd, dp);
            end
        end
    endtask

    task automatic test_glyphs();
        restart({5'd1, 5'd8, 5'd10, 5'd31});
        repeat (FRAME + 2) begin
            advance();
            vectors++;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++;
                $display("FAIL glyphs n=%0d: an=%b/%b seg=%h/%h fd=%b/%b (got/want)",
                         n, an, exp_an, seg, exp_seg, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_no_tearing();
        restart({4{5'd1}});
        repeat (2 * FRAME + 2) begin
            advance();
            if (n == 2 * SD + 4) data = {4{5'd8}};
            vectors++;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++;
                $display("FAIL no_tearing n=%0d: an=%b/%b seg=%h/%h fd=%b/%b (got/want)",
                         n, an, exp_an, seg, exp_seg, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_async_reset();
        restart(rand_data());
        repeat (2 * SD + 5) advance();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: an=%b seg=%h fd=%b, want 1111 7f 0", an, seg, frame_done);
        end
        data = rand_data();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (FRAME + 10) begin
            advance();
            vectors++;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++;
                $display("FAIL after_async n=%0d: an=%b/%b seg=%h/%h fd=%b/%b (got/want)",
                         n, an, exp_an, seg, exp_seg, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_dash_blank();
        restart({4{5'd29}});
        repeat (2 * FRAME) begin
            advance();
            if (n == FRAME / 2) data = {4{5'd31}};
            vectors++;
            if (an !== exp_an || seg !== exp_seg || dp !== 1'b1 || $countones(~an) > 1) begin
                errs++;
                $display("FAIL dash_blank n=%0d: an=%b/%b seg=%h/%h dp=%b (got/want)",
                         n, an, exp_an, seg, exp_seg, dp);
            end
        end
    endtask

    task automatic test_random();
        restart(rand_data());
        repeat (6 * FRAME) begin
            advance();
            if ($urandom_range(0, 3) == 0) data = rand_data();
            vectors++;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd || dp !== 1'b1
                || $countones(~an) > 1) begin
                errs++;
                $display("FAIL random n=%0d: an=%b/%b seg=%h/%h fd=%b/%b dp=%b (got/want)",
                         n, an, exp_an, seg, exp_seg, frame_done, exp_fd, dp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_glyphs();
        test_no_tearing();
        test_async_reset();
        test_dash_blank();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
